// File: rtl/inv_key_schedule_if.sv
// ============================================================================
// inv_key_schedule_if : start/seed request and round-key stream handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface inv_key_schedule_if;
  logic         start;
  logic [0:127] key;
  logic         ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] rk_data;
  logic [3:0]   rk_index;
  logic         done;

  modport master (
    output start, key, rk_ready,
    input  ready, rk_valid, rk_data, rk_index, done
  );

  modport slave (
    input  start, key, rk_ready,
    output ready, rk_valid, rk_data, rk_index, done
  );
endinterface

`default_nettype wire

// File: rtl/inv_key_schedule.sv
// ============================================================================
// inv_key_schedule : streams AES-128 round keys 10..0 from a round-10 seed,
// or from a cipher-key seed when INV_KEY_SCHEDULE_CIPHER_KEY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inv_key_schedule (
  input  logic                clk,
  input  logic                reset,
  inv_key_schedule_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
`ifdef INV_KEY_SCHEDULE_CIPHER_KEY_EN
    S_FWD  = 2'd3,
`endif
    S_FIN  = 2'd2
  } state_t;

  localparam logic [0:2047] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = c_sbox[{b, 3'b000} +: 8];
  endfunction

  // SubWord(RotWord(w)) with byte 0 in bits [31:24]
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    sub_rot = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    rcon = {v, 24'h000000};
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [0:127] r_key;
  logic [0:127] w_key_nxt;
  logic [3:0]   r_index;
  logic [3:0]   w_index_nxt;

  logic [31:0] w_c0, w_c1, w_c2, w_c3;
  logic [31:0] w_p0, w_p1, w_p2, w_p3;

  assign w_c0 = r_key[0  +: 32];
  assign w_c1 = r_key[32 +: 32];
  assign w_c2 = r_key[64 +: 32];
  assign w_c3 = r_key[96 +: 32];

  // Inverse step: recover round r-1 from round r
  assign w_p3 = w_c3 ^ w_c2;
  assign w_p2 = w_c2 ^ w_c1;
  assign w_p1 = w_c1 ^ w_c0;
  assign w_p0 = w_c0 ^ sub_rot(w_p3) ^ rcon(r_index);

`ifdef INV_KEY_SCHEDULE_CIPHER_KEY_EN
  logic [31:0] w_f0, w_f1, w_f2, w_f3;

  // Forward step: derive round r+1 from round r
  assign w_f0 = w_c0 ^ sub_rot(w_c3) ^ rcon(r_index + 4'd1);
  assign w_f1 = w_c1 ^ w_f0;
  assign w_f2 = w_c2 ^ w_f1;
  assign w_f3 = w_c3 ^ w_f2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_index <= w_index_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_index_nxt = r_index;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_key_nxt   = bus.key;
`ifdef INV_KEY_SCHEDULE_CIPHER_KEY_EN
          w_index_nxt = 4'd0;
          w_state_nxt = S_FWD;
`else
          w_index_nxt = 4'd10;
          w_state_nxt = S_EMIT;
`endif
        end
      end
`ifdef INV_KEY_SCHEDULE_CIPHER_KEY_EN
      S_FWD: begin
        w_key_nxt   = {w_f0, w_f1, w_f2, w_f3};
        w_index_nxt = r_index + 4'd1;
        if (r_index == 4'd9) begin
          w_state_nxt = S_EMIT;
        end
      end
`endif
      S_EMIT: begin
        if (bus.rk_ready) begin
          if (r_index == 4'd0) begin
            w_state_nxt = S_FIN;
          end else begin
            w_key_nxt   = {w_p0, w_p1, w_p2, w_p3};
            w_index_nxt = r_index - 4'd1;
          end
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.rk_valid = (r_state == S_EMIT);
  assign bus.done     = (r_state == S_FIN);
  assign bus.rk_data  = r_key;
  assign bus.rk_index = r_index;

endmodule

`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
// ============================================================================
// tb_inv_key_schedule : scoreboard bench for the inverse AES-128 key schedule
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inv_key_schedule;

  logic clk;
  logic reset;

  inv_key_schedule_if bus();

  inv_key_schedule dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [0:127] rk;
  } vec_t;

  vec_t tbl [0:10];
  vec_t sb [$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  bit pend_done = 1'b0;
  bit chk_ready_next = 1'b0;

`ifdef INV_KEY_SCHEDULE_CIPHER_KEY_EN
  localparam int c_lat = 11;
`else
  localparam int c_lat = 1;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rk_ready driver: mode 0 always accepts, mode 1 repeats 1-0-0-1
  initial begin
    int cyc;
    cyc = 0;
    bus.rk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) bus.rk_ready = 1'b1;
      else               bus.rk_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      cyc++;
    end
  end

  // Output monitor: every valid cycle must show the scoreboard head
  initial begin
    bit exp_d;
    forever begin
      @(negedge clk);
      exp_d = pend_done;
      pend_done = 1'b0;
      if (bus.done || exp_d) check("done_pulse", 128'(bus.done), 128'(exp_d));
      if (bus.done) begin
        done_cnt++;
        check("ready_in_fin", 128'(bus.ready), 128'd0);
        chk_ready_next = 1'b1;
      end else if (chk_ready_next) begin
        check("ready_after_fin", 128'(bus.ready), 128'd1);
        chk_ready_next = 1'b0;
      end
      if (bus.rk_valid) begin
        check("ready_busy", 128'(bus.ready), 128'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 128'd1, 128'd0);
        end else begin
          check("rk_index", 128'(bus.rk_index), 128'(sb[0].idx));
          check("rk_data", bus.rk_data, sb[0].rk);
          if (bus.rk_ready) begin
            if (sb[0].idx == 4'd0) pend_done = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_run();
    int lat;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
`ifdef INV_KEY_SCHEDULE_CIPHER_KEY_EN
    bus.key = tbl[0].rk;
`else
    bus.key = tbl[10].rk;
`endif
    @(posedge clk);
    for (int i = 10; i >= 0; i--) sb.push_back(tbl[i]);
    #1;
    bus.start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.rk_valid) check("ready_fwd", 128'(bus.ready), 128'd0);
    end while (!bus.rk_valid && lat < 40);
    check("first_valid_latency", 128'(lat), 128'(c_lat));
  endtask

  task automatic wait_finish(input bit start_in_fin);
    int n;
    int d0;
    d0 = done_cnt;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("finish_timeout", 128'(bus.done), 128'd1);
    if (start_in_fin) bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_valid", 128'(bus.rk_valid), 128'd0);
    end
    check("done_count", 128'(done_cnt - d0), 128'd1);
    check("scoreboard_empty", 128'(sb.size()), 128'd0);
  endtask

  task automatic wait_index(input logic [3:0] idx);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rk_valid && bus.rk_index == idx) && n < 200);
    check("wait_index_timeout", 128'(bus.rk_index), 128'(idx));
  endtask

  initial begin
    tbl[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(bus.ready), 128'd1);
    check("rst_valid", 128'(bus.rk_valid), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_data", bus.rk_data, 128'd0);
    check("rst_index", 128'(bus.rk_index), 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full-rate stream
    rdy_mode = 0;
    start_run();
    wait_finish(1'b0);

    // Stalled stream
    rdy_mode = 1;
    start_run();
    wait_finish(1'b0);

    // Start mid-run and in FIN are both ignored
    rdy_mode = 0;
    start_run();
    wait_index(4'd5);
    bus.start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ready_during_restart", 128'(bus.ready), 128'd0);
    end
    bus.start = 1'b0;
    wait_finish(1'b1);

    // Reset in the middle of a run
    start_run();
    wait_index(4'd6);
    #2;
    reset = 1'b1;
    sb.delete();
    pend_done = 1'b0;
    chk_ready_next = 1'b0;
    #1;
    check("midrst_valid", 128'(bus.rk_valid), 128'd0);
    check("midrst_ready", 128'(bus.ready), 128'd1);
    check("midrst_done", 128'(bus.done), 128'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_valid", 128'(bus.rk_valid), 128'd0);
      check("postrst_done", 128'(bus.done), 128'd0);
    end
    start_run();
    wait_finish(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
